// File: rtl/bit_selection_stream_ctrl.sv
// bit_selection_stream_ctrl
// Unpacks back-to-back LSB-first fields of 1..16 bits from a stream of
// 16-bit words. It keeps a two-word window {hi, lo} and a bit offset, and
// presents both to the downstream 32x16 bit selector, one field per cycle
// while enough data are buffered.
//
// Optional build macro: BIT_SEL_STREAM_CTRL_CNT_EN
//   When defined, adds o_field_cnt[15:0], a wrapping count of emitted fields
//   that is cleared by reset and by i_flush.
module bit_selection_stream_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int IN_WIDTH      = DATA_WIDTH / 2,
  parameter int COMMAND_WIDTH = $clog2(DATA_WIDTH) - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic [COMMAND_WIDTH-1:0] i_cfg_len,
  input  logic                     i_valid,
  input  logic [IN_WIDTH-1:0]      i_data,
  output logic                     o_ready,
  output logic                     o_sel_valid,
  output logic [DATA_WIDTH-1:0]    o_sel_data_bus,
  output logic [COMMAND_WIDTH-1:0] o_sel_cmd,
  input  logic                     i_sel_ready,
  output logic                     o_busy
`ifdef BIT_SEL_STREAM_CTRL_CNT_EN
  ,
  output logic [15:0]              o_field_cnt
`endif
);

  // Width that holds off + L without overflow (15 + 16 = 31).
  localparam int SUM_W = COMMAND_WIDTH + 1;
  localparam logic [SUM_W-1:0] WORD_BITS = SUM_W'(IN_WIDTH);

  // Window slots: index 0 is the older word (lo), index 1 the newer (hi).
  logic [1:0][IN_WIDTH-1:0] slot_reg;
  logic [1:0][IN_WIDTH-1:0] slot_next;
  logic [1:0][IN_WIDTH-1:0] slot_shifted;
  logic [1:0]               words_reg;
  logic [1:0]               words_next;
  logic [1:0]               words_shifted;
  logic [COMMAND_WIDTH-1:0] off_reg;
  logic [COMMAND_WIDTH-1:0] off_next;

  logic [SUM_W-1:0] field_len;
  logic [SUM_W-1:0] off_sum;
  logic             emit;
  logic             shift;
  logic             accept;
  logic             wr_idx;

  // Field length decode; a zero length code stands for a full 16-bit field.
  assign field_len = (i_cfg_len == '0) ? WORD_BITS : {1'b0, i_cfg_len};
  assign off_sum   = {1'b0, off_reg} + field_len;

  // A field is offered only if all of its bits are already in the window,
  // so a field never straddles a word that has not arrived yet.
  assign o_sel_valid = (words_reg == 2'd2) ||
                       ((words_reg == 2'd1) && (off_sum <= WORD_BITS));
  assign emit  = o_sel_valid && i_sel_ready;
  // Crossing into the newer word retires the older one.
  assign shift = emit && off_sum[SUM_W-1];

  // A slot is free if one is empty now or one is being retired this cycle.
  // During a flush the input is dropped, so ready is simply held high.
  assign o_ready = i_flush || (words_reg < 2'd2) || shift;
  assign accept  = i_valid && o_ready && !i_flush;

  assign o_sel_data_bus = {slot_reg[1], slot_reg[0]};
  assign o_sel_cmd      = off_reg;
  assign o_busy         = (words_reg != 2'd0);

  // Occupancy after any same-cycle retire decides where a new word lands.
  assign words_shifted = words_reg - {1'b0, shift};
  assign wr_idx        = (words_shifted != 2'd0);
  assign words_next    = words_shifted + {1'b0, accept};

  // After a shift the new offset is off_sum-16, otherwise off_sum; both are
  // just the low bits of the sum since off_sum never reaches 32.
  assign off_next = emit ? off_sum[COMMAND_WIDTH-1:0] : off_reg;

  // Per-slot next value: retire-shift first, then place an accepted word.
  // The vacated hi slot is zero-filled so empty bits read as 0.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      if (gi == 0) begin : g_lo
        assign slot_shifted[gi] = shift ? slot_reg[1] : slot_reg[0];
      end else begin : g_hi
        assign slot_shifted[gi] = shift ? '0 : slot_reg[1];
      end
      assign slot_next[gi] = (accept && (wr_idx == 1'(gi))) ? i_data
                                                            : slot_shifted[gi];
    end
  endgenerate

  // Window, occupancy and offset registers; flush wins over accept/emit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_reg  <= '0;
      words_reg <= '0;
      off_reg   <= '0;
    end else if (i_flush) begin
      slot_reg  <= '0;
      words_reg <= '0;
      off_reg   <= '0;
    end else begin
      slot_reg  <= slot_next;
      words_reg <= words_next;
      off_reg   <= off_next;
    end
  end

`ifdef BIT_SEL_STREAM_CTRL_CNT_EN
  logic [15:0] field_cnt_reg;

  // Wrapping count of emitted fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      field_cnt_reg <= '0;
    end else if (i_flush) begin
      field_cnt_reg <= '0;
    end else if (emit) begin
      field_cnt_reg <= field_cnt_reg + 16'd1;
    end
  end

  assign o_field_cnt = field_cnt_reg;
`endif

endmodule

// File: tb/tb_bit_selection_stream_ctrl.sv
// Directed bench for bit_selection_stream_ctrl. With
// BIT_SEL_STREAM_CTRL_CNT_EN defined it also exercises the field counter.
module tb_bit_selection_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_flush;
  logic [3:0]  i_cfg_len;
  logic        i_valid;
  logic [15:0] i_data;
  logic        o_ready;
  logic        o_sel_valid;
  logic [31:0] o_sel_data_bus;
  logic [3:0]  o_sel_cmd;
  logic        i_sel_ready;
  logic        o_busy;
`ifdef BIT_SEL_STREAM_CTRL_CNT_EN
  logic [15:0] o_field_cnt;
`endif

  int checks = 0;
  int errors = 0;

  bit_selection_stream_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .i_flush        (i_flush),
    .i_cfg_len      (i_cfg_len),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .o_ready        (o_ready),
    .o_sel_valid    (o_sel_valid),
    .o_sel_data_bus (o_sel_data_bus),
    .o_sel_cmd      (o_sel_cmd),
    .i_sel_ready    (i_sel_ready),
    .o_busy         (o_busy)
`ifdef BIT_SEL_STREAM_CTRL_CNT_EN
    ,
    .o_field_cnt    (o_field_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] win;

    rst         = 1'b0;
    i_flush     = 1'b0;
    i_cfg_len   = 4'd0;
    i_valid     = 1'b0;
    i_data      = 16'h0000;
    i_sel_ready = 1'b0;
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_sel_valid), 32'd0);
    chk("rst_bus", o_sel_data_bus, 32'h0);
    chk("rst_cmd", 32'(o_sel_cmd), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    step();

    // L=16: two words loaded under backpressure, then drained.
    i_valid = 1'b1; i_data = 16'h0810; step();
    i_data = 16'hA442; step();
    i_valid = 1'b0; #1;
    chk("l16_bus1", o_sel_data_bus, 32'hA4420810);
    chk("l16_cmd1", 32'(o_sel_cmd), 32'd0);
    chk("l16_valid1", 32'(o_sel_valid), 32'd1);
    chk("l16_full_ready", 32'(o_ready), 32'd0);
    i_sel_ready = 1'b1; #1;
    chk("l16_shift_ready", 32'(o_ready), 32'd1);
    step();
    chk("l16_bus2", o_sel_data_bus, 32'h0000A442);
    chk("l16_cmd2", 32'(o_sel_cmd), 32'd0);
    chk("l16_valid2", 32'(o_sel_valid), 32'd1);
    step();
    chk("l16_busy_end", 32'(o_busy), 32'd0);
    chk("l16_valid_end", 32'(o_sel_valid), 32'd0);

    // L=4: one word gives four nibble fields.
    i_sel_ready = 1'b0; i_cfg_len = 4'd4;
    i_valid = 1'b1; i_data = 16'h0810; step();
    i_valid = 1'b0; i_sel_ready = 1'b1; #1;
    chk("l4_bus", o_sel_data_bus, 32'h00000810);
    chk("l4_cmd0", 32'(o_sel_cmd), 32'd0);
    win = o_sel_data_bus >> o_sel_cmd;
    chk("l4_nib0", win & 32'hF, 32'h0);
    step();
    chk("l4_cmd4", 32'(o_sel_cmd), 32'd4);
    win = o_sel_data_bus >> o_sel_cmd;
    chk("l4_nib1", win & 32'hF, 32'h1);
    step();
    chk("l4_cmd8", 32'(o_sel_cmd), 32'd8);
    win = o_sel_data_bus >> o_sel_cmd;
    chk("l4_nib2", win & 32'hF, 32'h8);
    step();
    chk("l4_cmd12", 32'(o_sel_cmd), 32'd12);
    chk("l4_valid12", 32'(o_sel_valid), 32'd1);
    win = o_sel_data_bus >> o_sel_cmd;
    chk("l4_nib3", win & 32'hF, 32'h0);
    step();
    chk("l4_valid_end", 32'(o_sel_valid), 32'd0);
    chk("l4_busy_end", 32'(o_busy), 32'd0);
    chk("l4_ready_end", 32'(o_ready), 32'd1);

    // L=12: second field must wait for the second word.
    i_sel_ready = 1'b0; i_cfg_len = 4'd12;
    i_valid = 1'b1; i_data = 16'h0810; step();
    i_valid = 1'b0; #1;
    chk("l12_valid1", 32'(o_sel_valid), 32'd1);
    chk("l12_cmd1", 32'(o_sel_cmd), 32'd0);
    i_sel_ready = 1'b1; step();
    chk("l12_wait_valid", 32'(o_sel_valid), 32'd0);
    chk("l12_wait_cmd", 32'(o_sel_cmd), 32'd12);
    i_valid = 1'b1; i_data = 16'hA442; step();
    i_valid = 1'b0; #1;
    chk("l12_valid2", 32'(o_sel_valid), 32'd1);
    chk("l12_bus2", o_sel_data_bus, 32'hA4420810);
    step();
    chk("l12_cmd3", 32'(o_sel_cmd), 32'd8);
    chk("l12_bus3", o_sel_data_bus, 32'h0000A442);
    chk("l12_valid3", 32'(o_sel_valid), 32'd0);
    chk("l12_busy3", 32'(o_busy), 32'd1);
    i_flush = 1'b1; step();
    i_flush = 1'b0; #1;
    chk("l12_flush_busy", 32'(o_busy), 32'd0);

    // L=8 backpressure, then release with simultaneous accept on shift.
    i_sel_ready = 1'b0; i_cfg_len = 4'd8;
    i_valid = 1'b1; i_data = 16'h0810; step();
    i_data = 16'hA442; step();
    i_valid = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_bus", o_sel_data_bus, 32'hA4420810);
      chk("bp_cmd", 32'(o_sel_cmd), 32'd0);
      chk("bp_valid", 32'(o_sel_valid), 32'd1);
      chk("bp_ready", 32'(o_ready), 32'd0);
      step();
    end
    i_sel_ready = 1'b1; step();
    chk("bp_cmd8", 32'(o_sel_cmd), 32'd8);
    chk("bp_bus8", o_sel_data_bus, 32'hA4420810);
    i_valid = 1'b1; i_data = 16'h1234; #1;
    chk("bp_shift_ready", 32'(o_ready), 32'd1);
    step();
    i_valid = 1'b0; #1;
    chk("bp_bus_new", o_sel_data_bus, 32'h1234A442);
    chk("bp_cmd_new", 32'(o_sel_cmd), 32'd0);

    // Flush with words=2, off=5 and a same-cycle input that must be dropped.
    i_sel_ready = 1'b0;
    i_flush = 1'b1; step();
    i_flush = 1'b0; i_cfg_len = 4'd5;
    i_valid = 1'b1; i_data = 16'h0810; step();
    i_data = 16'hA442; step();
    i_valid = 1'b0; i_sel_ready = 1'b1; step();
    i_sel_ready = 1'b0; #1;
    chk("fl_cmd5", 32'(o_sel_cmd), 32'd5);
    chk("fl_ready_full", 32'(o_ready), 32'd0);
    i_flush = 1'b1; i_valid = 1'b1; i_data = 16'hBEEF; #1;
    chk("fl_ready_during", 32'(o_ready), 32'd1);
    step();
    i_flush = 1'b0; i_valid = 1'b0; #1;
    chk("fl_busy", 32'(o_busy), 32'd0);
    chk("fl_cmd", 32'(o_sel_cmd), 32'd0);
    chk("fl_valid", 32'(o_sel_valid), 32'd0);
    chk("fl_bus", o_sel_data_bus, 32'h0);

    // Asynchronous reset mid-stream.
    i_valid = 1'b1; i_data = 16'h5555; step();
    i_valid = 1'b0; #1;
    chk("ar_busy_before", 32'(o_busy), 32'd1);
    chk("ar_bus_before", o_sel_data_bus, 32'h00005555);
    rst = 1'b0; #1;
    chk("ar_bus", o_sel_data_bus, 32'h0);
    chk("ar_busy", 32'(o_busy), 32'd0);
    chk("ar_valid", 32'(o_sel_valid), 32'd0);
    chk("ar_ready", 32'(o_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    step();

`ifdef BIT_SEL_STREAM_CTRL_CNT_EN
    // 70000 L=16 fields, one per cycle, then a flush.
    chk("cnt_start", 32'(o_field_cnt), 32'd0);
    i_cfg_len = 4'd0; i_sel_ready = 1'b1; i_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      i_data = 16'(i);
      step();
    end
    i_valid = 1'b0;
    repeat (3) step();
    chk("cnt_wrap", 32'(o_field_cnt), 32'd4464);
    i_flush = 1'b1; step();
    i_flush = 1'b0; #1;
    chk("cnt_flush", 32'(o_field_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_selection_stream_ctrl.md
Name: bit_selection_stream_ctrl

Overview:
- Sequencer that feeds bit_selection_32x16_seq from a stream of 16-bit words.
- Unpacks back-to-back variable-length fields of L bits (1..16), LSB-first.
- Keeps a two-word 32-bit window and produces, per field, the window (`o_sel_data_bus`) and bit offset (`o_sel_cmd`) for the selector. The selector returns `window[cmd+15:cmd]`; the downstream consumer keeps the low L bits.
- Sits between the input NoC port and the selector's `i_valid`/`i_data_bus`/`i_cmd`.

Parameters:
- DATA_WIDTH, 32, selector window width; only 32 is supported.
- IN_WIDTH, DATA_WIDTH/2 (16), width of each input word.
- COMMAND_WIDTH, $clog2(DATA_WIDTH)-1 (4), width of the offset command.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- i_flush  in  1  synchronous drop of all buffered data.
- i_cfg_len  in  COMMAND_WIDTH  field length; 0 encodes 16, 1..15 literal.
- i_valid  in  1  input word valid.
- i_data  in  IN_WIDTH  input word.
- o_ready  out  1  input word accepted when i_valid && o_ready.
- o_sel_valid  out  1  field available to the selector.
- o_sel_data_bus  out  DATA_WIDTH  window, {newer word, older word}.
- o_sel_cmd  out  COMMAND_WIDTH  bit offset of the field LSB in the window.
- i_sel_ready  in  1  selector/downstream accepts the field.
- o_busy  out  1  words != 0.

Behaviour:
- State registers:
  - `lo`, `hi`: 16 bits each.
  - `words`: 0..2, number of valid words.
  - `off`: 0..15.
- Combinational outputs:
  - `o_sel_data_bus` = {hi, lo}; `o_sel_cmd` = off.
- Reset (rst=0, async): lo=hi=0, words=0, off=0. All outputs therefore reset to 0, except o_ready=1.
- L = (i_cfg_len==0) ? 16 : i_cfg_len. i_cfg_len may change only while o_busy=0; a change while busy is unsupported.
- o_sel_valid = (words==2) || (words==1 && off+L<=16). A field is never split across an absent word.
- emit = o_sel_valid && i_sel_ready.
- On emit:
  - noff = off+L (0..31).
  - If noff>=16 (shift): lo<=hi, words decrements, off<=noff-16.
  - Else: off<=noff.
- o_ready = (words<2) || (emit && shift). This is combinational on i_sel_ready.
- On accept, the word goes to the lowest free slot after any same-cycle shift:
  - slot 0 if resulting words==0, otherwise slot 1.
  - words increments.
- Simultaneous cases:
  - emit+shift+accept with words=2: lo<=hi, hi<=i_data, words stays 2.
  - emit+shift+accept with words=1: lo<=i_data, words stays 1.
- Latency:
  - A field is presented combinationally from registered state.
  - Accepted input becomes visible on the next cycle.
  - Throughput is one field per cycle while data are sufficient.
- Backpressure: while i_sel_ready=0, o_sel_data_bus, o_sel_cmd and o_sel_valid hold stable unless an input accept fills hi. Filling hi changes bits outside the already-valid field only.
- i_flush=1 (takes priority over accept/emit): next cycle words=0, off=0, lo=hi=0. o_ready stays 1 during flush; the flush-cycle input is dropped.
- Empty-slot bits (hi when words<=1) read as 0.
- Reset mid-operation clears everything immediately. No partial field is emitted afterwards.

Optional Feature:
- Macro BIT_SEL_STREAM_CTRL_CNT_EN.
- Defined: adds output o_field_cnt [15:0]:
  - Counts emits; wraps 0xFFFF -> 0.
  - Cleared by rst and i_flush.
  - Increments on the emit cycle; the new value is visible on the next cycle.
- Undefined: no port, no counter logic. Behaviour is otherwise identical.

Test Plan:
- L=16 (cfg 0); feed 0x0810 then 0xA442, i_sel_ready=1 -> first emit window 0xA4420810 cmd 0 (selector field 0x0810). Next emit window 0x0000A442 cmd 0 (field 0xA442); then words=0, o_busy=0.
- L=4; feed only 0x0810 -> four emits with cmd 0,4,8,12 from window 0x00000810 (low nibbles 0,1,8,0). Then o_sel_valid=0, words=0, o_ready=1.
- L=12; feed 0x0810, 0xA442 ->
  - emit 1: cmd 0, 1 word allowed.
  - emit 2: cmd 12, waits for the second word (24>16); shift, then off=8.
  - emit 3: only 1 word remains and 8+12>16 -> o_sel_valid=0.
- Backpressure: L=8, two words loaded, i_sel_ready=0 for 3 cycles -> outputs constant, o_ready=0. Release -> cmd 0 then 8; shift and simultaneous accept of 0x1234 gives window 0x1234A442 cmd 0.
- i_flush with words=2, off=5, same cycle i_valid=1 -> next cycle words=0, off=0, o_sel_valid=0, word dropped. Async rst low mid-stream -> outputs zero immediately.
- With BIT_SEL_STREAM_CTRL_CNT_EN: 70000 L=16 emits -> o_field_cnt = 70000 mod 65536 = 4464. Flush -> 0.
